// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared state and port encodings for the upram arbiter
package ram_arbiter_pkg;
  typedef enum logic {ARB, LOCKED} arb_state_t;
  typedef enum logic {PORT_CPU, PORT_HOST} port_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: CPU, host and upram signals bundled for the arbiter
interface ram_arbiter_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
  logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              host_req, host_we, host_lock, host_gnt, host_rvalid, lock_err;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] rdata, ram_data, ram_q;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_wren;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  host_req, host_we, host_lock, host_addr, host_wdata, ram_q,
    output cpu_gnt, cpu_rvalid, cpu_stall, host_gnt, host_rvalid, lock_err,
    output rdata, ram_address, ram_data, ram_wren
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output host_req, host_we, host_lock, host_addr, host_wdata, ram_q,
    input  cpu_gnt, cpu_rvalid, cpu_stall, host_gnt, host_rvalid, lock_err,
    input  rdata, ram_address, ram_data, ram_wren
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of upram between CPU and host loader,
// with a host lock mode bounded by LOCK_MAX cycles.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 64
) (
  input  logic         clk,
  input  logic         reset,
  ram_arbiter_if.slave bus
);
  localparam int CW = $clog2(LOCK_MAX);
  arb_state_t    state, state_n;
  port_t         rr_last, rr_n;
  logic [CW-1:0] lock_cnt, cnt_n;
  logic          lock_blk, blk_n, lock_err, rv_cpu, rv_host;
  logic          cpu_gnt, host_gnt, timeout;
  always_comb begin
    cpu_gnt  = state == ARB && bus.cpu_req && (!bus.host_req || rr_last == PORT_HOST);
    host_gnt = bus.host_req && (state == LOCKED || !bus.cpu_req || rr_last == PORT_CPU);
    timeout  = state == LOCKED && bus.host_lock && lock_cnt == CW'(LOCK_MAX - 1);
    state_n  = state == ARB ? ((host_gnt && bus.host_lock && !lock_blk) ? LOCKED : ARB)
                            : ((!bus.host_lock || timeout) ? ARB : LOCKED);
    rr_n     = (timeout || host_gnt) ? PORT_HOST : cpu_gnt ? PORT_CPU : rr_last;
    cnt_n    = state == LOCKED ? lock_cnt + CW'(1) : '0;
    blk_n    = timeout || (lock_blk && bus.host_lock);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARB;
      rr_last  <= PORT_HOST;
      lock_cnt <= '0;
      lock_blk <= 1'b0;
      lock_err <= 1'b0;
      rv_cpu   <= 1'b0;
      rv_host  <= 1'b0;
    end else begin
      state    <= state_n;
      rr_last  <= rr_n;
      lock_cnt <= cnt_n;
      lock_blk <= blk_n;
      lock_err <= lock_err || timeout;
      rv_cpu   <= cpu_gnt && !bus.cpu_we;
      rv_host  <= host_gnt && !bus.host_we;
    end
  end
  assign bus.cpu_gnt     = cpu_gnt;
  assign bus.host_gnt    = host_gnt;
  assign bus.cpu_stall   = bus.cpu_req && !cpu_gnt;
  assign bus.cpu_rvalid  = rv_cpu;
  assign bus.host_rvalid = rv_host;
  assign bus.lock_err    = lock_err;
  assign bus.rdata       = bus.ram_q;
  assign bus.ram_wren    = (cpu_gnt && bus.cpu_we) || (host_gnt && bus.host_we);
  assign bus.ram_address = cpu_gnt ? bus.cpu_addr : host_gnt ? bus.host_addr : {ADDR_W{1'b0}};
  assign bus.ram_data    = cpu_gnt ? bus.cpu_wdata : host_gnt ? bus.host_wdata : {DATA_W{1'b0}};
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench; dut uses default LOCK_MAX, dut8 shares stimulus with LOCK_MAX=8
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;
  typedef struct packed {port_t p; logic [7:0] d;} rd_t;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  ram_arbiter_if a ();
  ram_arbiter_if b ();
  ram_arbiter dut (.clk(clk), .reset(reset), .bus(a));
  ram_arbiter #(.LOCK_MAX(8)) dut8 (.clk(clk), .reset(reset), .bus(b));
  assign b.cpu_req    = a.cpu_req;
  assign b.cpu_we     = a.cpu_we;
  assign b.cpu_addr   = a.cpu_addr;
  assign b.cpu_wdata  = a.cpu_wdata;
  assign b.host_req   = a.host_req;
  assign b.host_we    = a.host_we;
  assign b.host_lock  = a.host_lock;
  assign b.host_addr  = a.host_addr;
  assign b.host_wdata = a.host_wdata;
  logic [7:0] mem_a [256] = '{default: 8'h00};
  logic [7:0] mem_b [256] = '{default: 8'h00};
  logic [7:0] sh    [256] = '{default: 8'h00};
  always @(posedge clk) begin
    if (a.ram_wren) mem_a[a.ram_address] <= a.ram_data;
    a.ram_q <= mem_a[a.ram_address];
  end
  always @(posedge clk) begin
    if (b.ram_wren) mem_b[b.ram_address] <= b.ram_data;
    b.ram_q <= mem_b[b.ram_address];
  end
  rd_t sb[$];
  rd_t e;
  int n_chk = 0, n_pass = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(negedge clk)
    if (!reset && (a.cpu_rvalid || a.host_rvalid)) begin
      if (sb.size() == 0) chk("sb_nonempty", 32'(sb.size() != 0), 1);
      else begin
        e = sb.pop_front();
        chk("rv_port", a.host_rvalid, e.p == PORT_HOST);
        chk("rv_single", a.cpu_rvalid & a.host_rvalid, 0);
        chk("rdata", a.rdata, e.d);
      end
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    a.cpu_req = 0; a.cpu_we = 0; a.host_req = 0; a.host_we = 0; a.host_lock = 0;
  endtask
  task automatic rst_pulse();
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
  endtask
  initial begin
    logic ec, eh;
    idle();
    a.cpu_addr = 0; a.cpu_wdata = 0; a.host_addr = 0; a.host_wdata = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_cpu_gnt", a.cpu_gnt, 0);
    chk("rst_host_gnt", a.host_gnt, 0);
    chk("rst_cpu_rvalid", a.cpu_rvalid, 0);
    chk("rst_host_rvalid", a.host_rvalid, 0);
    chk("rst_wren", a.ram_wren, 0);
    chk("rst_lock_err", a.lock_err, 0);
    chk("rst_addr", a.ram_address, 0);
    chk("rst_data", a.ram_data, 0);
    // host write then CPU read-back
    step();
    a.host_req = 1; a.host_we = 1; a.host_addr = 8'h10; a.host_wdata = 8'hA5;
    @(negedge clk);
    chk("t1_host_gnt", a.host_gnt, 1);
    chk("t1_wren", a.ram_wren, 1);
    chk("t1_addr", a.ram_address, 8'h10);
    chk("t1_data", a.ram_data, 8'hA5);
    sh[8'h10] = 8'hA5;
    step();
    a.host_req = 0; a.host_we = 0; a.cpu_req = 1; a.cpu_we = 0; a.cpu_addr = 8'h10;
    @(negedge clk);
    chk("t1_cpu_gnt", a.cpu_gnt, 1);
    chk("t1_rd_wren", a.ram_wren, 0);
    sb.push_back(rd_t'{PORT_CPU, sh[8'h10]});
    step();
    a.cpu_req = 0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("t1_rvalid_once", a.cpu_rvalid, 0);
    // round-robin with both requesting
    rst_pulse();
    a.cpu_req = 1; a.host_req = 1; a.host_addr = 8'h20;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ec = (k % 2) == 0;
      chk("t2_cpu_gnt", a.cpu_gnt, ec);
      chk("t2_host_gnt", a.host_gnt, !ec);
      chk("t2_stall", a.cpu_stall, !ec);
      sb.push_back(ec ? rd_t'{PORT_CPU, sh[8'h10]} : rd_t'{PORT_HOST, sh[8'h20]});
      step();
    end
    idle();
    @(negedge clk);
    step();
    chk("t2_sb_empty", sb.size(), 0);
    // locked burst of 16 host writes
    rst_pulse();
    a.host_req = 1; a.host_lock = 1; a.host_we = 1;
    for (int i = 0; i < 16; i++) begin
      a.host_addr = 8'(i); a.host_wdata = 8'(i) ^ 8'h5A;
      a.cpu_req = i > 0;
      if (i == 15) a.host_lock = 0;
      @(negedge clk);
      chk("t3_host_gnt", a.host_gnt, 1);
      chk("t3_cpu_gnt", a.cpu_gnt, 0);
      chk("t3_stall", a.cpu_stall, i > 0);
      sh[i] = 8'(i) ^ 8'h5A;
      step();
    end
    a.host_req = 0; a.host_we = 0;
    @(negedge clk);
    chk("t3_cpu_after", a.cpu_gnt, 1);
    sb.push_back(rd_t'{PORT_CPU, sh[8'h10]});
    step();
    a.cpu_req = 0; a.host_req = 1; a.host_addr = 8'h05;
    @(negedge clk);
    chk("t3_host_rd", a.host_gnt, 1);
    sb.push_back(rd_t'{PORT_HOST, sh[8'h05]});
    step();
    idle();
    @(negedge clk);
    step();
    chk("t3_sb_empty", sb.size(), 0);
    chk("t3_no_err", a.lock_err, 0);
    // lock timeout on dut8
    rst_pulse();
    a.host_req = 1; a.host_lock = 1; a.host_we = 1; a.host_addr = 8'hF0; a.host_wdata = 8'h33;
    a.cpu_we = 1; a.cpu_addr = 8'hF1; a.cpu_wdata = 8'h44;
    for (int k = 0; k < 20; k++) begin
      a.cpu_req = k > 0;
      @(negedge clk);
      eh = k <= 8 || (k > 9 && k % 2 == 0);
      ec = k > 0 && !eh;
      chk("t4_host_gnt", b.host_gnt, eh);
      chk("t4_cpu_gnt", b.cpu_gnt, ec);
      chk("t4_stall", b.cpu_stall, k > 0 && !ec);
      chk("t4_lock_err", b.lock_err, k >= 9);
      step();
    end
    a.host_lock = 0;
    @(negedge clk);
    chk("t4_k20_host", b.host_gnt, 1);
    step();
    a.host_lock = 1;
    @(negedge clk);
    chk("t4_k21_cpu", b.cpu_gnt, 1);
    step();
    @(negedge clk);
    chk("t4_relock_host", b.host_gnt, 1);
    step();
    @(negedge clk);
    chk("t4_relocked_host", b.host_gnt, 1);
    chk("t4_relocked_stall", b.cpu_stall, 1);
    step();
    idle();
    @(negedge clk);
    step();
    // reset right after a CPU read grant
    chk("t5_err_before", b.lock_err, 1);
    a.cpu_req = 1; a.cpu_we = 0; a.cpu_addr = 8'h10;
    @(negedge clk);
    chk("t5_cpu_gnt", a.cpu_gnt, 1);
    @(posedge clk);
    #1 reset = 1;
    a.cpu_req = 0;
    #1;
    chk("t5_rvalid_async", a.cpu_rvalid, 0);
    chk("t5_err_cleared", b.lock_err, 0);
    chk("t5_wren", a.ram_wren, 0);
    chk("t5_addr", a.ram_address, 0);
    @(negedge clk);
    chk("t5_rvalid_hold", a.cpu_rvalid, 0);
    step();
    reset = 0;
    @(negedge clk);
    chk("t5_rvalid_after", a.cpu_rvalid, 0);
    chk("t5_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
